// File: rtl/schmidl_cox_pkg.sv
// Shared types and field widths for the Schmidl-Cox timing-sync blocks.
package schmidl_cox_pkg;

    localparam int unsigned SC_P_W   = 16;
    localparam int unsigned SC_R_W   = 16;
    localparam int unsigned SC_IDX_W = 32;
    localparam int unsigned SC_THR_W = 16;

    // Peak-detector control states.
    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        EMIT,
        HOLDOFF
    } sc_state_t;

    // One metric-calculator beat: |P(d)| in the upper half, R(d) in the lower half.
    typedef struct packed {
        logic [SC_P_W-1:0] p;
        logic [SC_R_W-1:0] r;
    } sc_beat_t;

endpackage

// File: rtl/schmidl_cox_peak_detector.sv
// Divider-free threshold detector and plateau peak locator for the Schmidl-Cox
// metric stream; emits one sample index per detected preamble.
module schmidl_cox_peak_detector
    import schmidl_cox_pkg::*;
#(
    parameter int unsigned FFT_SIZE = 16,
    parameter int unsigned GAP_LEN  = FFT_SIZE / 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [SC_THR_W-1:0] threshold,
    input  logic [31:0]         i_tdata,
    input  logic                i_tlast,
    input  logic                i_tvalid,
    output logic                i_tready,
    output logic [SC_IDX_W-1:0] o_tdata,
    output logic                o_tlast,
    output logic                o_tvalid,
    input  logic                o_tready
);

    localparam int unsigned GAP_W  = $clog2(GAP_LEN + 1);
    localparam int unsigned HOLD_W = $clog2(FFT_SIZE + 1);

    sc_state_t             state, state_nxt;
    logic [SC_IDX_W-1:0]   idx, idx_nxt;
    logic [SC_IDX_W-1:0]   peak_idx, peak_idx_nxt;
    logic [SC_P_W-1:0]     max_p, max_p_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;

    sc_beat_t              beat_c;
    logic                  accept_c;
    logic                  above_c;
    logic [31:0]           scaled_p_c;
    logic [31:0]           thr_r_c;
    logic                  unused_tlast;

    assign unused_tlast = i_tlast;

    // Beat decode, handshake and M(d) > threshold test as P*2^16 > threshold*R.
    assign beat_c     = sc_beat_t'(i_tdata);
    assign accept_c   = i_tvalid && i_tready;
    assign scaled_p_c = {beat_c.p, 16'b0};
    assign thr_r_c    = 32'(threshold) * 32'(beat_c.r);
    assign above_c    = scaled_p_c > thr_r_c;

    // Next-state and datapath update for detect / track / emit / holdoff.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        peak_idx_nxt = peak_idx;
        max_p_nxt    = max_p;
        gap_cnt_nxt  = gap_cnt;
        hold_cnt_nxt = hold_cnt;

        if (accept_c) begin
            idx_nxt = idx + SC_IDX_W'(1);
        end

        case (state)
            IDLE: begin
                if (accept_c && above_c) begin
                    max_p_nxt    = beat_c.p;
                    peak_idx_nxt = idx;
                    gap_cnt_nxt  = '0;
                    state_nxt    = TRACK;
                end
            end
            TRACK: begin
                if (accept_c) begin
                    // Strict compare keeps the earliest index on ties.
                    if (beat_c.p > max_p) begin
                        max_p_nxt    = beat_c.p;
                        peak_idx_nxt = idx;
                    end
                    if (above_c) begin
                        gap_cnt_nxt = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                        if (gap_cnt_nxt == GAP_W'(GAP_LEN)) begin
                            state_nxt = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                if (o_tready) begin
                    hold_cnt_nxt = HOLD_W'(FFT_SIZE);
                    state_nxt    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (accept_c) begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                    if (hold_cnt_nxt == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered handshake outputs decoded from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            peak_idx <= '0;
            max_p    <= '0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
            i_tready <= 1'b1;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
        end else if (clear) begin
            state    <= IDLE;
            idx      <= '0;
            peak_idx <= '0;
            max_p    <= '0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
            i_tready <= 1'b1;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            peak_idx <= peak_idx_nxt;
            max_p    <= max_p_nxt;
            gap_cnt  <= gap_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            i_tready <= (state_nxt != EMIT);
            o_tvalid <= (state_nxt == EMIT);
            o_tlast  <= (state_nxt == EMIT);
            if (state_nxt == EMIT) begin
                o_tdata <= peak_idx_nxt;
            end
        end
    end

endmodule

// File: doc/schmidl_cox_peak_detector.md
# schmidl_cox_peak_detector

Consumes the per-sample Schmidl-Cox statistic stream produced by the metric calculator in the `rfnoc_block_schmidl_cox` chain. It detects threshold crossings of M(d) = |P(d)| / R(d) without a divider and locates the timing peak inside the plateau. It emits one 32-bit sample index per detected preamble on an AXI-Stream output. It sits directly downstream of the metric calculator and feeds the frame-timing/CP-removal logic.

## Interface
- `FFT_SIZE`, 16: OFDM symbol length; holdoff length in samples.
- `GAP_LEN`, `FFT_SIZE/2`: consecutive below-threshold samples that close a plateau.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `clear` in 1: synchronous, active-high soft reset with the same effect as `reset`.
- `threshold` in 16: UQ0.16 metric threshold; static while not in IDLE.
- `i_tdata` in 32: `[31:16]` = P, unsigned |P(d)|-scaled; `[15:0]` = R, unsigned R(d)-scaled.
- `i_tlast` in 1: ignored.
- `i_tvalid` in 1: input beat valid.
- `i_tready` out 1: input ready.
- `o_tdata` out 32: index of the peak sample.
- `o_tlast` out 1: equals `o_tvalid`; one-beat packets.
- `o_tvalid` out 1: output beat valid.
- `o_tready` in 1: output ready.

## Operation
- **Accept.** A beat is accepted when `i_tvalid && i_tready`.
- **Sample counter `idx`.** 32 bits, 0 after reset/clear. Each accepted beat is tagged with the current `idx`, then `idx` increments, wrapping 2^32−1 → 0.
- **Crossing test.** `above = ({P,16'b0} > threshold*R)`. The product is 32-bit unsigned and the compare is strict. With R=0: P>0 is above; P=0 is not.
- **FSM, `IDLE`.**
  - On an accepted beat with `above`: load `max_p`=P and `peak_idx`=idx, clear `gap_cnt`, go to `TRACK`.
- **FSM, `TRACK`.** Per accepted beat:
  - If P > `max_p` (strict), update `max_p` and `peak_idx`. Ties keep the earlier index.
  - `above` clears `gap_cnt`. Otherwise `gap_cnt++`.
  - When `gap_cnt` reaches `GAP_LEN`, go to `EMIT`. Below-threshold samples still take part in the max update.
- **FSM, `EMIT`.**
  - `o_tvalid`=1 and `o_tdata`=`peak_idx`; `i_tready`=0.
  - On `o_tready`: go to `HOLDOFF` and load `hold_cnt`=`FFT_SIZE`.
- **FSM, `HOLDOFF`.**
  - Accepted beats decrement `hold_cnt` and are not tested.
  - The beat that brings `hold_cnt` to 0 returns the FSM to `IDLE`. The next beat is tested.
- **`i_tready`.** 1 in every state except `EMIT`.
- **Reset/clear.** Take effect in any state, including mid-`TRACK` or mid-`EMIT`. FSM goes to `IDLE`; all counters and registers go to 0. Any pending output is dropped.

## Timing
- **Reset values:** `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `i_tready`=1.
- **Latency:** `o_tvalid` rises in the cycle after the edge that accepts the `GAP_LEN`-th consecutive below-threshold beat.
- **Output stability:** `o_tdata` is held stable while `o_tvalid && !o_tready`.
- **Back-to-back:** the output handshake edge returns `i_tready` to 1 in the next cycle.
- **No combinational paths:** none from `o_tready` to `i_tready` and none from `i_tvalid` to `o_tvalid`. Both ready and valid are state-decoded.
- **Throughput:** one input beat per cycle outside `EMIT`.
- **Simultaneous events:** `clear` overrides any handshake in the same cycle.

## Structure
- **`schmidl_cox_pkg`:**
  - state enum `sc_state_t` {IDLE, TRACK, EMIT, HOLDOFF}
  - field-width constants: `SC_P_W`=16, `SC_R_W`=16, `SC_IDX_W`=32, `SC_THR_W`=16
- **Sub-modules:** none needed. The comparator, counters and FSM live in one module, roughly 150–250 lines.

## Test plan
All scenarios use `FFT_SIZE`=16, `GAP_LEN`=8, `threshold`=0x8000, R=1000.

1. P=400 for 100 beats → no output; `i_tready` stays 1.
2. Indices 0–19 P=400; 20–27 P=600 except P=800 at 23; then P=100 → single output `o_tdata`=23 one cycle after accepting index 35.
3. As scenario 2 but P=800 at 22 and 25 → `o_tdata`=22.
4. Scenario 2 with `o_tready`=0 for 10 cycles → `i_tready`=0 and `o_tdata`=23 held for those 10 cycles. Exactly one transfer occurs.
5. After scenario 2's handshake, another above-threshold burst inside the next 16 accepted beats → ignored. A burst after holdoff → detected with the correct absolute index.
6. Assert `reset` low during `TRACK`, and separately `clear` during `EMIT` → no output, `o_tvalid`=0; `idx` restarts at 0. Scenario 2 then repeats with output 23.
